irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of interrupt channels, legal range 1..16.
REQ-002 Parameter BASE_ADDR, default 16'hFF00, base of the 8-byte register window, 8-byte aligned.
REQ-003 Parameter LEVEL_MASK, default {NUM_IRQ{1'b0}}, bit n = 1 makes channel n level-sensitive, 0 makes it rising-edge.
REQ-004 I_clk  in  1  clock; all state changes on the rising edge.
REQ-005 I_reset  in  1  synchronous, active-high reset.
REQ-006 I_irq_lines  in  NUM_IRQ  interrupt request lines, synchronous to I_clk.
REQ-007 I_irq_ack  in  1  core acknowledge, one-cycle pulse.
REQ-008 O_irq_active  out  1  request to core, registered.
REQ-009 O_vector  out  16  vector number, valid while O_vector_valid is high.
REQ-010 O_vector_valid  out  1  high for the single cycle after an ack cycle.
REQ-011 I_bus_exec, I_bus_write  in  1 each  bus transaction strobe and direction.
REQ-012 I_bus_addr  in  16  byte address; I_bus_data  in  16  write data.
REQ-013 O_bus_data  out  16  read data; O_bus_data_ready  out  1  read data valid; O_bus_ready  out  1  always 1 outside reset.

Function
REQ-014 Registers, offset from BASE_ADDR: +0 PENDING (read; write-1-to-clear), +2 MASK (read/write; 1 = enabled), +4 INSERVICE (read-only), +6 EOI (write-only; any write clears the highest-priority INSERVICE bit).
REQ-015 Unused upper register bits read 0; writes to bits >= NUM_IRQ have no effect.
REQ-016 Reads complete in 1 cycle: O_bus_data and O_bus_data_ready are valid the cycle after the I_bus_exec cycle; out-of-window accesses produce no O_bus_data_ready and change no state.
REQ-017 Edge channel: PENDING[n] sets on a 0->1 transition of I_irq_lines[n] versus its value registered the previous cycle.
REQ-018 Level channel: PENDING[n] equals the registered I_irq_lines[n]; W1C has no effect on it.
REQ-019 Priority: lower index wins; eligible = PENDING & MASK & ~INSERVICE; the winner W is the lowest eligible index.
REQ-020 Preemption: a request is raised only if W is lower than the lowest set INSERVICE index, or INSERVICE is 0.
REQ-021 FSM states: IDLE, REQ, VEC.
REQ-022 IDLE -> REQ when a qualifying W exists; O_irq_active = 1 in REQ.
REQ-023 REQ -> IDLE without ack when no qualifying W remains (masked, cleared, or level dropped); O_irq_active falls the next cycle.
REQ-024 REQ + I_irq_ack -> VEC: on that edge, latch O_vector = W, set INSERVICE[W], clear PENDING[W] if W is an edge channel, and drop O_irq_active.
REQ-025 If no qualifying W exists in the ack cycle, O_vector = 16'hFFFF (spurious) and state is unchanged.
REQ-026 VEC lasts exactly 1 cycle with O_vector_valid = 1, then -> IDLE.
REQ-027 I_irq_ack in IDLE or VEC is ignored.
REQ-028 Edge set and W1C clear of the same bit in the same cycle: set wins.
REQ-029 EOI and ack in the same cycle: EOI clears the old highest INSERVICE bit first, then the new W bit is set.
REQ-030 EOI with INSERVICE = 0 has no effect.

Reset
REQ-031 I_reset asserted in any state, including mid-REQ or VEC, forces: state IDLE, PENDING/MASK/INSERVICE = 0, edge history = 0, O_irq_active = 0, O_vector = 0, O_vector_valid = 0, O_bus_data = 0, O_bus_data_ready = 0, O_bus_ready = 0.
REQ-032 The first cycle after reset deassertion cannot register an edge from a line held high during reset.

Structure
REQ-033 Register offsets, the SPURIOUS_VECTOR constant and the FSM state encodings live in the shared header alongside the ctrl states and memory map; BASE_ADDR defaults from the memory map.
REQ-034 One sub-module, irq_prio_enc (NUM_IRQ-bit lowest-index encoder with a valid flag), is used for both W and the lowest INSERVICE index.

Verification
REQ-035 MASK = 16'h0005, pulse line 2 -> O_irq_active 1 cycle later; ack -> next cycle O_vector = 2, O_vector_valid = 1, INSERVICE = 16'h0004, PENDING = 0.
REQ-036 Lines 0 and 2 rise together, all enabled -> vector 0 first; line 2 stays pending; EOI -> request re-raised, vector 2.
REQ-037 INSERVICE = 16'h0008, channel 1 pends -> preempting request, vector 1; channel 5 pends -> no request until both EOIs.
REQ-038 In REQ, write MASK = 0 -> O_irq_active drops; ack in the same cycle as the drop -> O_vector = 16'hFFFF, INSERVICE unchanged.
REQ-039 Level channel 3 held high with LEVEL_MASK bit 3 set -> after ack and EOI, re-requests; W1C PENDING = 16'h0008 does not clear it.
REQ-040 Assert reset during VEC -> next cycle all outputs 0, state IDLE; read of BASE_ADDR+2 returns 0.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: memory map, register offsets,
// vector constants and controller state encodings.
package irq_ctrl_pkg;

  localparam logic [15:0] IRQ_CTRL_BASE = 16'hFF00;

  localparam logic [2:0] OFF_PENDING   = 3'd0;
  localparam logic [2:0] OFF_MASK      = 3'd2;
  localparam logic [2:0] OFF_INSERVICE = 3'd4;
  localparam logic [2:0] OFF_EOI       = 3'd6;

  localparam logic [15:0] SPURIOUS_VECTOR = 16'hFFFF;

  // wide enough to index up to 16 channels
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_VEC  = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins encoder: reports the index of the lowest set bit and
// whether any bit is set at all.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller with edge/level channels, nesting by priority,
// and an 8-byte bus register window (PENDING, MASK, INSERVICE, EOI).
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ    = 8,
  parameter logic [15:0]        BASE_ADDR  = IRQ_CTRL_BASE,
  parameter logic [NUM_IRQ-1:0] LEVEL_MASK = {NUM_IRQ{1'b0}}
) (
  input  logic               I_clk,
  input  logic               I_reset,
  input  logic [NUM_IRQ-1:0] I_irq_lines,
  input  logic               I_irq_ack,
  output logic               O_irq_active,
  output logic [15:0]        O_vector,
  output logic               O_vector_valid,
  input  logic               I_bus_exec,
  input  logic               I_bus_write,
  input  logic [15:0]        I_bus_addr,
  input  logic [15:0]        I_bus_data,
  output logic [15:0]        O_bus_data,
  output logic               O_bus_data_ready,
  output logic               O_bus_ready
);

  logic [NUM_IRQ-1:0] line_q, pend_q, mask_q, insv_q;
  logic               armed_q;
  ctrl_state_e        state_q, state_d;

  logic [NUM_IRQ-1:0] pending, eligible, edge_set, w1c, win_bit, eoi_bit, wdata;
  logic [IDX_W-1:0]   win_idx, insv_idx;
  logic               win_valid, insv_valid, qualify, ack_take;
  logic               in_win, rd_en, wr_pend, wr_mask, wr_eoi;
  logic [2:0]         off;
  logic [15:0]        rd_val;
  logic [15:0]        unused_wdata;

  assign unused_wdata = I_bus_data;
  assign wdata        = I_bus_data[NUM_IRQ-1:0];

  // Level channels mirror the registered line; only edge channels keep latched state.
  assign pending  = (pend_q & ~LEVEL_MASK) | (line_q & LEVEL_MASK);
  assign eligible = pending & mask_q & ~insv_q;

  irq_prio_enc #(.N(NUM_IRQ)) u_win_enc (
    .req   (eligible),
    .idx   (win_idx),
    .valid (win_valid)
  );

  irq_prio_enc #(.N(NUM_IRQ)) u_insv_enc (
    .req   (insv_q),
    .idx   (insv_idx),
    .valid (insv_valid)
  );

  assign qualify = win_valid && (!insv_valid || (win_idx < insv_idx));

  assign off     = I_bus_addr[2:0];
  assign in_win  = I_bus_exec && (I_bus_addr[15:3] == BASE_ADDR[15:3]);
  assign rd_en   = in_win && !I_bus_write;
  assign wr_pend = in_win && I_bus_write && (off == OFF_PENDING);
  assign wr_mask = in_win && I_bus_write && (off == OFF_MASK);
  assign wr_eoi  = in_win && I_bus_write && (off == OFF_EOI);

  always_comb begin
    rd_val = '0;
    case (off)
      OFF_PENDING:   rd_val = 16'(pending);
      OFF_MASK:      rd_val = 16'(mask_q);
      OFF_INSERVICE: rd_val = 16'(insv_q);
      default:       rd_val = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ack_take = 1'b0;
    case (state_q)
      ST_IDLE: if (qualify) state_d = ST_REQ;
      ST_REQ: begin
        if (I_irq_ack && qualify) begin
          state_d  = ST_VEC;
          ack_take = 1'b1;
        end else if (!qualify) begin
          state_d = ST_IDLE;
        end
      end
      ST_VEC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Edges are suppressed for the first cycle out of reset, when line_q is still 0.
  assign edge_set = I_irq_lines & ~line_q & ~LEVEL_MASK & {NUM_IRQ{armed_q}};
  assign w1c      = wr_pend ? wdata : '0;

  always_comb begin
    win_bit = '0;
    eoi_bit = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      win_bit[i] = ack_take && (win_idx == IDX_W'(i));
      eoi_bit[i] = wr_eoi && insv_valid && (insv_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_q          <= ST_IDLE;
      line_q           <= '0;
      pend_q           <= '0;
      mask_q           <= '0;
      insv_q           <= '0;
      armed_q          <= 1'b0;
      O_irq_active     <= 1'b0;
      O_vector         <= '0;
      O_vector_valid   <= 1'b0;
      O_bus_data       <= '0;
      O_bus_data_ready <= 1'b0;
      O_bus_ready      <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= I_irq_lines;
      armed_q  <= 1'b1;
      // set wins over both W1C and the ack clear
      pend_q   <= ((pend_q & ~w1c & ~win_bit) | edge_set) & ~LEVEL_MASK;
      // EOI retires the old top bit before the newly acked bit is added
      insv_q   <= (insv_q & ~eoi_bit) | win_bit;
      if (wr_mask) mask_q <= wdata;
      O_irq_active   <= (state_d == ST_REQ);
      O_vector_valid <= (state_q == ST_REQ) && I_irq_ack;
      if ((state_q == ST_REQ) && I_irq_ack)
        O_vector <= qualify ? 16'(win_idx) : SPURIOUS_VECTOR;
      O_bus_data       <= rd_en ? rd_val : '0;
      O_bus_data_ready <= rd_en;
      O_bus_ready      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus randomized traffic, all checked
// against a behavioural interrupt-controller model.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [7:0]  LVL  = 8'h08;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  lines = '0;
  logic        ack = 1'b0;
  logic        exec = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, wdata = '0;

  logic        O_irq_active, O_vector_valid, O_bus_data_ready, O_bus_ready;
  logic [15:0] O_vector, O_bus_data;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl #(.NUM_IRQ(8), .BASE_ADDR(BASE), .LEVEL_MASK(LVL)) dut (
    .I_clk            (clk),
    .I_reset          (rst),
    .I_irq_lines      (lines),
    .I_irq_ack        (ack),
    .O_irq_active     (O_irq_active),
    .O_vector         (O_vector),
    .O_vector_valid   (O_vector_valid),
    .I_bus_exec       (exec),
    .I_bus_write      (wr),
    .I_bus_addr       (addr),
    .I_bus_data       (wdata),
    .O_bus_data       (O_bus_data),
    .O_bus_data_ready (O_bus_data_ready),
    .O_bus_ready      (O_bus_ready)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [7:0]  m_pend = '0, m_prev = '0, m_mask = '0, m_ins = '0;
  bit          m_arm = 0, m_active = 0, m_vec = 0, m_valid = 0, m_bus_rdy = 0, m_rd_rdy = 0;
  logic [15:0] m_vector = '0, m_rd_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 99;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [7:0] p, elig, clr, edges, nxt_ins;
    int w, l;
    bit qual, inwin, took;
    if (rst) begin
      m_pend = '0; m_prev = '0; m_mask = '0; m_ins = '0;
      m_arm = 0; m_active = 0; m_vec = 0; m_valid = 0;
      m_bus_rdy = 0; m_rd_rdy = 0; m_vector = '0; m_rd_data = '0;
      return;
    end
    p     = (m_pend & ~LVL) | (m_prev & LVL);
    elig  = p & m_mask & ~m_ins;
    w     = lowest(elig);
    l     = lowest(m_ins);
    qual  = (w < 8) && (w < l);
    inwin = exec && (addr[15:3] == BASE[15:3]);
    m_rd_rdy  = inwin && !wr;
    m_rd_data = '0;
    if (m_rd_rdy) begin
      if (addr[2:0] == 3'd0) m_rd_data = {8'h00, p};
      if (addr[2:0] == 3'd2) m_rd_data = {8'h00, m_mask};
      if (addr[2:0] == 3'd4) m_rd_data = {8'h00, m_ins};
    end
    clr = '0;
    if (inwin && wr && addr[2:0] == 3'd0) clr = wdata[7:0];
    nxt_ins = m_ins;
    if (inwin && wr && addr[2:0] == 3'd6 && l < 8) nxt_ins[l] = 1'b0;
    took    = m_active && ack;
    m_valid = took;
    if (took) begin
      if (qual) begin
        m_vector   = 16'(w);
        nxt_ins[w] = 1'b1;
        clr[w]     = 1'b1;
      end else begin
        m_vector = 16'hFFFF;
      end
    end
    edges  = lines & ~m_prev & ~LVL & (m_arm ? 8'hFF : 8'h00);
    m_pend = ((m_pend & ~clr) | edges) & ~LVL;
    if (inwin && wr && addr[2:0] == 3'd2) m_mask = wdata[7:0];
    m_active  = m_vec ? 1'b0 : (qual && !took);
    m_vec     = took && qual;
    m_ins     = nxt_ins;
    m_prev    = lines;
    m_arm     = 1;
    m_bus_rdy = 1;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("active", O_irq_active, m_active);
    check("valid", O_vector_valid, m_valid);
    check("vector", O_vector, m_vector);
    check("bus_ready", O_bus_ready, m_bus_rdy);
    check("data_ready", O_bus_data_ready, m_rd_rdy);
    if (m_rd_rdy) check("rd_data", O_bus_data, m_rd_data);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    exec = 1; wr = 1; addr = a; wdata = d;
    tick();
    exec = 0; wr = 0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    exec = 1; wr = 0; addr = a;
    tick();
    exec = 0;
    d = O_bus_data;
  endtask

  task automatic do_ack();
    ack = 1;
    tick();
    ack = 0;
  endtask

  task automatic eoi();
    bus_write(BASE + 16'd6, 16'h0000);
  endtask

  task automatic wait_active(input string tag);
    int n = 0;
    while (!O_irq_active && n < 20) begin
      tick();
      n++;
    end
    check(tag, O_irq_active, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;

    // reset with lines held high: no phantom edges afterwards
    rst = 1; lines = 8'h0F;
    repeat (3) tick();
    check("rst active", O_irq_active, 0);
    check("rst vector", O_vector, 0);
    check("rst bus_ready", O_bus_ready, 0);
    rst = 0;
    tick();
    check("bus_ready up", O_bus_ready, 1);
    bus_read(BASE, d);
    check("no edge after reset", d, 16'h0008);
    lines = 8'h00;
    tick();

    // basic request/ack
    bus_write(BASE + 16'd2, 16'h0005);
    lines = 8'h04; tick(); lines = 8'h00;
    check("035 not yet", O_irq_active, 0);
    tick();
    check("035 request", O_irq_active, 1);
    do_ack();
    check("035 vector", O_vector, 2);
    check("035 valid", O_vector_valid, 1);
    check("035 active drop", O_irq_active, 0);
    bus_read(BASE + 16'd4, d); check("035 inservice", d, 16'h0004);
    bus_read(BASE, d);         check("035 pending", d, 16'h0000);
    eoi();
    bus_read(BASE + 16'd4, d); check("035 eoi", d, 16'h0000);

    // simultaneous edges, lower index first
    bus_write(BASE + 16'd2, 16'h00FF);
    lines = 8'h05; tick(); lines = 8'h00;
    wait_active("036 req0");
    do_ack();
    check("036 vector0", O_vector, 0);
    bus_read(BASE, d); check("036 pending2", d, 16'h0004);
    eoi();
    wait_active("036 req2");
    do_ack();
    check("036 vector2", O_vector, 2);
    eoi();

    // nesting and preemption
    lines = 8'h08;
    wait_active("037 req3");
    do_ack();
    check("037 vector3", O_vector, 3);
    lines = 8'h00; tick();
    bus_read(BASE + 16'd4, d); check("037 ins8", d, 16'h0008);
    lines = 8'h02; tick(); lines = 8'h00;
    wait_active("037 preempt");
    do_ack();
    check("037 vector1", O_vector, 1);
    bus_read(BASE + 16'd4, d); check("037 ins0a", d, 16'h000A);
    lines = 8'h20; tick(); lines = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("037 ch5 held", O_irq_active, 0);
    end
    bus_read(BASE, d); check("037 pending5", d, 16'h0020);
    eoi();
    tick();
    check("037 still held", O_irq_active, 0);
    bus_read(BASE + 16'd4, d); check("037 ins after eoi", d, 16'h0008);
    eoi();
    wait_active("037 req5");
    do_ack();
    check("037 vector5", O_vector, 5);
    eoi();

    // mask drop while requesting -> spurious ack
    lines = 8'h01; tick(); lines = 8'h00;
    wait_active("038 req");
    bus_write(BASE + 16'd2, 16'h0000);
    check("038 still req", O_irq_active, 1);
    do_ack();
    check("038 spurious", O_vector, SPURIOUS_VECTOR);
    check("038 dropped", O_irq_active, 0);
    bus_read(BASE + 16'd4, d); check("038 ins", d, 16'h0000);
    bus_write(BASE, 16'h0001);
    bus_write(BASE + 16'd2, 16'h00FF);

    // level channel re-requests and ignores W1C
    lines = 8'h08;
    wait_active("039 req");
    do_ack();
    check("039 vector", O_vector, 3);
    bus_write(BASE, 16'h0008);
    bus_read(BASE, d); check("039 w1c ignored", d, 16'h0008);
    eoi();
    wait_active("039 rereq");
    do_ack();
    eoi();
    lines = 8'h00;
    tick(); tick();

    // edge set beats same-cycle W1C
    lines = 8'h01;
    bus_write(BASE, 16'h0001);
    lines = 8'h00;
    bus_read(BASE, d); check("028 set wins", d[0], 1'b1);
    wait_active("028 req");
    do_ack();
    check("028 vector", O_vector, 0);
    eoi();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      lines = lines ^ 8'($urandom & $urandom & $urandom);
      ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 599) == 0);
      if (r < 8) begin
        exec = 1; wr = 1; addr = BASE + 16'd2; wdata = 16'($urandom);
      end else if (r < 14) begin
        exec = 1; wr = 1; addr = BASE; wdata = 16'($urandom);
      end else if (r < 20) begin
        exec = 1; wr = 1; addr = BASE + 16'd6; wdata = 16'($urandom);
      end else if (r < 23) begin
        exec = 1; wr = $urandom_range(0, 1); addr = BASE - 16'd8 + 16'($urandom_range(0, 7));
        wdata = 16'($urandom);
      end else if (r < 40) begin
        exec = 1; wr = 0; addr = BASE + 16'($urandom_range(0, 7));
      end
      tick();
      exec = 0; wr = 0; ack = 0; rst = 0;
    end

    // reset in VEC
    lines = 8'h00; tick();
    bus_write(BASE + 16'd2, 16'h00FF);
    lines = 8'h02; tick(); lines = 8'h00;
    wait_active("040 req");
    do_ack();
    check("040 in vec", O_vector_valid, 1);
    rst = 1;
    tick();
    check("040 active", O_irq_active, 0);
    check("040 vector", O_vector, 0);
    check("040 valid", O_vector_valid, 0);
    check("040 data", O_bus_data, 0);
    check("040 data_ready", O_bus_data_ready, 0);
    check("040 bus_ready", O_bus_ready, 0);
    rst = 0;
    tick();
    bus_read(BASE + 16'd2, d); check("040 mask", d, 16'h0000);
    bus_read(BASE + 16'd4, d); check("040 ins", d, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
